imm_decode_sequencer: RTL and testbench
=======================================

IMM_DECODE_SEQUENCER -- requirements
Module: imm_decode_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  instruction offered.
REQ-005 in_ready  output  1  block accepts instr this cycle; transfer when in_valid & in_ready at posedge.
REQ-006 instr  input  32  raw RV32I instruction word.
REQ-007 unsigned_mode  input  1  sampled with instr; 1 = zero-extend I (OP-IMM/LOAD) and B immediates.
REQ-008 out_valid  output  1  FIFO head valid.
REQ-009 out_ready  input  1  consumer takes head when out_valid & out_ready at posedge.
REQ-010 imm_out  output  32  extended immediate of head entry.
REQ-011 imm_fmt  output  3  head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-012 illegal  output  1  head entry was an unrecognised instruction.
REQ-013 trap_clear  input  1  leaves TRAP state (used only with IMM_TRAP_EN).

Function
REQ-014 opcode = instr[6:2]; instr[1:0] != 2'b11 SHALL be illegal.
REQ-015 I format: 00100 OP-IMM, 00000 LOAD, 11001 JALR; imm = instr[31:20] sign-extended, zero-extended when unsigned_mode=1 except JALR (always signed).
REQ-016 S format: 01000 STORE; imm = {instr[31:25], instr[11:7]} sign-extended.
REQ-017 B format: 11000 BRANCH; imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} sign-extended from bit 12, zero-extended when unsigned_mode=1.
REQ-018 U format: 01101 LUI, 00101 AUIPC; imm = {instr[31:12], 12'd0}.
REQ-019 J format: 11011 JAL; imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} sign-extended from bit 20.
REQ-020 NONE format, legal: 01100 OP, 00011 MISC-MEM, 11100 SYSTEM; imm = 0.
REQ-021 Any other opcode SHALL be illegal; entry stored with imm=0, fmt=0, illegal=1.
REQ-022 Decoded result SHALL be pushed into a 2-entry output FIFO on the accepting edge; latency 1 cycle (out_valid high the cycle after acceptance when FIFO was empty).
REQ-023 in_ready = (count < 2) & (state == RUN); no combinational path from out_ready to in_ready, so a full FIFO refuses input even while popping.
REQ-024 Simultaneous push and pop with count==1 SHALL keep count at 1 and preserve order.
REQ-025 Read/write pointers are 1 bit and wrap 1->0; count ranges 0..2, never over/underflows.
REQ-026 With FIFO empty: out_valid=0, imm_out=0, imm_fmt=0, illegal=0.
REQ-027 FSM states RUN and TRAP; TRAP reachable only with IMM_TRAP_EN.

Reset
REQ-028 rst SHALL immediately clear count, pointers, and all outputs to 0 (out_valid=0, imm_out=0, imm_fmt=0, illegal=0), set state=RUN, and make in_ready=1 after release.
REQ-029 rst mid-operation SHALL discard all queued entries; no entry survives reset.

Configuration
REQ-030 Macro IMM_TRAP_EN defined: accepting an illegal instr pushes its entry and moves RUN->TRAP; in TRAP in_ready=0; TRAP->RUN on the edge where trap_clear=1 and count==0.
REQ-031 Macro IMM_TRAP_EN undefined: state stays RUN, illegal entries pass through flagged, trap_clear ignored.

Verification
REQ-032 instr=32'hFFF00093 (addi -1), unsigned_mode=0 -> next cycle imm_out=32'hFFFFFFFF, fmt=1; unsigned_mode=1 -> 32'h00000FFF.
REQ-033 instr=32'hFE112E23 (sw x1,-4(x2)) -> imm_out=32'hFFFFFFFC, fmt=2; instr=32'hFE000CE3 (beq -8) -> 32'hFFFFFFF8, fmt=3; instr=32'h123450B7 (lui) -> 32'h12345000, fmt=4.
REQ-034 out_ready=0, three back-to-back valid instrs -> two accepted, in_ready=0 on third; out_ready=1 -> entries popped in order, third accepted once count<2.
REQ-035 instr=32'h00000000 with IMM_TRAP_EN -> illegal=1, in_ready stays 0 until head popped and trap_clear=1; without macro in_ready stays 1.
REQ-036 rst asserted with 2 entries queued -> out_valid=0 same cycle (asynchronous), FIFO empty after release, first new instr emerges with latency 1.

Source files
------------

// File: rtl/imm_decode_sequencer_if.sv
// Handshake and data bundle for imm_decode_sequencer.
// slave is the decoder's view; master is the driver/consumer view.
interface imm_decode_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        unsigned_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_out;
  logic [2:0]  imm_fmt;
  logic        illegal;
  logic        trap_clear;

  modport master (
    output in_valid, instr, unsigned_mode, out_ready, trap_clear,
    input  in_ready, out_valid, imm_out, imm_fmt, illegal
  );

  modport slave (
    input  in_valid, instr, unsigned_mode, out_ready, trap_clear,
    output in_ready, out_valid, imm_out, imm_fmt, illegal
  );
endinterface

// File: rtl/imm_decode_sequencer.sv
// RV32I immediate decoder feeding a 2-entry output FIFO.
// Optional macro IMM_TRAP_EN: an accepted illegal instruction stalls input until trap_clear.
module imm_decode_sequencer (
  input  logic                    clk,
  input  logic                    rst,
  imm_decode_sequencer_if.slave   bus
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
    FMT_B    = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        wptr_q, rptr_q;
  logic [31:0] imm_mem_q [2];
  logic [2:0]  fmt_mem_q [2];
  logic        ill_mem_q [2];

  logic [31:0] dec_imm;
  fmt_e        dec_fmt;
  logic        dec_ill;
  logic        in_ready_w, out_valid_w, push, pop;

  // Instruction decode
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    if (bus.instr[1:0] != 2'b11) begin
      dec_ill = 1'b1;
    end else begin
      unique case (bus.instr[6:2])
        5'b00100, 5'b00000: begin
          dec_fmt = FMT_I;
          dec_imm = {{20{bus.instr[31] & ~bus.unsigned_mode}}, bus.instr[31:20]};
        end
        5'b11001: begin
          dec_fmt = FMT_I;
          dec_imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
        end
        5'b01000: begin
          dec_fmt = FMT_S;
          dec_imm = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
        end
        5'b11000: begin
          dec_fmt = FMT_B;
          dec_imm = {{19{bus.instr[31] & ~bus.unsigned_mode}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
        end
        5'b01101, 5'b00101: begin
          dec_fmt = FMT_U;
          dec_imm = {bus.instr[31:12], 12'd0};
        end
        5'b11011: begin
          dec_fmt = FMT_J;
          dec_imm = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20],
                     bus.instr[30:21], 1'b0};
        end
        5'b01100, 5'b00011, 5'b11100: dec_fmt = FMT_NONE;
        default: dec_ill = 1'b1;
      endcase
    end
  end

  assign in_ready_w  = (count_q != 2'd2) && (state_q == RUN);
  assign out_valid_w = (count_q != 2'd0);
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  // State and FIFO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      count_q <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        imm_mem_q[i] <= '0;
        fmt_mem_q[i] <= '0;
        ill_mem_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        imm_mem_q[wptr_q] <= dec_imm;
        fmt_mem_q[wptr_q] <= dec_fmt;
        ill_mem_q[wptr_q] <= dec_ill;
        wptr_q            <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
`ifdef IMM_TRAP_EN
    unique case (state_q)
      RUN:  if (push && dec_ill) state_d = TRAP;
      TRAP: if (bus.trap_clear && (count_q == 2'd0)) state_d = RUN;
      default: state_d = RUN;
    endcase
`else
    state_d = RUN;
`endif
  end

`ifndef IMM_TRAP_EN
  logic unused_trap_clear;
  assign unused_trap_clear = bus.trap_clear;
`endif

  // Outputs: head fields are forced to zero while the FIFO is empty
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.out_valid = out_valid_w;
    bus.imm_out   = '0;
    bus.imm_fmt   = '0;
    bus.illegal   = 1'b0;
    if (out_valid_w) begin
      bus.imm_out = imm_mem_q[rptr_q];
      bus.imm_fmt = fmt_mem_q[rptr_q];
      bus.illegal = ill_mem_q[rptr_q];
    end
  end

endmodule

// File: tb/tb_imm_decode_sequencer.sv
// Randomised and directed bench for imm_decode_sequencer against a queue-based reference model.
module tb_imm_decode_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_decode_sequencer_if bus ();

  imm_decode_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  ent_t q[$];
  bit   m_trap;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Immediate values built arithmetically from field weights, then sign-folded.
  function automatic ent_t ref_decode(logic [31:0] w, logic um);
    ent_t e;
    int   v;
    e.imm = 0; e.fmt = 0; e.ill = 0;
    if (w[1:0] != 2'b11) begin e.ill = 1; return e; end
    case (w[6:2])
      5'b00100, 5'b00000, 5'b11001: begin
        v = int'(w[31:20]);
        if ((w[6:2] == 5'b11001 || !um) && v >= 2048) v -= 4096;
        e.imm = v; e.fmt = 1;
      end
      5'b01000: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v -= 4096;
        e.imm = v; e.fmt = 2;
      end
      5'b11000: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (!um && v >= 4096) v -= 8192;
        e.imm = v; e.fmt = 3;
      end
      5'b01101, 5'b00101: begin e.imm = w & 32'hFFFFF000; e.fmt = 4; end
      5'b11011: begin
        v = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
            + int'(w[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        e.imm = v; e.fmt = 5;
      end
      5'b01100, 5'b00011, 5'b11100: e.fmt = 0;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic compare_outputs();
    logic        ev;
    logic [31:0] ei;
    logic [2:0]  ef;
    logic        el;
    ev = (q.size() > 0);
    ei = ev ? q[0].imm : 32'd0;
    ef = ev ? q[0].fmt : 3'd0;
    el = ev ? q[0].ill : 1'b0;
    check("out_valid", 32'(bus.out_valid), 32'(ev));
    check("imm_out",   bus.imm_out, ei);
    check("imm_fmt",   32'(bus.imm_fmt), 32'(ef));
    check("illegal",   32'(bus.illegal), 32'(el));
    check("in_ready",  32'(bus.in_ready), 32'((q.size() < 2) && !m_trap));
  endtask

  // One clock: check at negedge, drive, then advance the model at the posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic um,
                      input logic ordy, input logic tc);
    bit   do_push, do_pop;
    int   sz0;
    ent_t e;
    @(negedge clk);
    compare_outputs();
    bus.in_valid = v; bus.instr = ins; bus.unsigned_mode = um;
    bus.out_ready = ordy; bus.trap_clear = tc;
    sz0     = q.size();
    do_push = v && (sz0 < 2) && !m_trap;
    do_pop  = (sz0 > 0) && ordy;
    e       = ref_decode(ins, um);
    @(posedge clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e);
`ifdef IMM_TRAP_EN
    if (!m_trap && do_push && e.ill) m_trap = 1;
    else if (m_trap && tc && sz0 == 0) m_trap = 0;
`endif
  endtask

  task automatic head_is(input string tag, input logic [31:0] imm, input logic [2:0] fmt);
    #2;
    check({tag, "_imm"}, bus.imm_out, imm);
    check({tag, "_fmt"}, 32'(bus.imm_fmt), 32'(fmt));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  ops [16];
    logic [31:0] w;
    ops = '{5'b00100, 5'b00000, 5'b11001, 5'b01000, 5'b11000, 5'b01101, 5'b00101, 5'b11011,
            5'b01100, 5'b00011, 5'b11100, 5'b00100, 5'b11000, 5'b01000, 5'b11011, 5'b10101};
    w = $urandom;
    w[6:2] = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 15)];
    if ($urandom_range(0, 19) != 0) w[1:0] = 2'b11;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.instr = '0; bus.unsigned_mode = 0;
    bus.out_ready = 0; bus.trap_clear = 0;
    q.delete(); m_trap = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // reset state and known vectors
    step(0, 0, 0, 0, 0);
    step(1, 32'hFFF00093, 0, 1, 0); head_is("addi_s", 32'hFFFFFFFF, 3'd1);
    step(1, 32'hFFF00093, 1, 1, 0); head_is("addi_u", 32'h00000FFF, 3'd1);
    step(1, 32'hFE112E23, 0, 1, 0); head_is("sw",     32'hFFFFFFFC, 3'd2);
    step(1, 32'hFE000CE3, 0, 1, 0); head_is("beq",    32'hFFFFFFF8, 3'd3);
    step(1, 32'h123450B7, 0, 1, 0); head_is("lui",    32'h12345000, 3'd4);
    step(0, 0, 0, 1, 0);

    // backpressure: third back-to-back offer refused until a slot frees
    step(1, 32'h00100093, 0, 0, 0);
    step(1, 32'h00200093, 0, 0, 0);
    step(1, 32'h00300093, 0, 0, 0);
    #2 check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1, 32'h00300093, 0, 1, 0);
    step(1, 32'h00300093, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // all-zero word is illegal
    step(1, 32'h00000000, 0, 0, 0);
    #2 check("zero_illegal", 32'(bus.illegal), 32'd1);
`ifdef IMM_TRAP_EN
    check("trap_in_ready", 32'(bus.in_ready), 32'd0);
`else
    check("notrap_in_ready", 32'(bus.in_ready), 32'd1);
`endif
    step(1, 32'h00100093, 0, 1, 1);
    step(1, 32'h00100093, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);

    // randomised traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), 1'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // asynchronous reset with two entries queued
    step(1, 32'h00500093, 0, 0, 0);
    step(1, 32'hFE112E23, 0, 0, 0);
    #2 check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 0; bus.out_ready = 0; bus.trap_clear = 0;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_imm_out",   bus.imm_out, 32'd0);
    check("rst_imm_fmt",   32'(bus.imm_fmt), 32'd0);
    q.delete(); m_trap = 0;
    @(negedge clk) rst = 1'b0;
    step(1, 32'h0FF00013, 0, 0, 0); head_is("post_rst", 32'h000000FF, 3'd1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    compare_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
